mmul_c_writeback_ctrl: RTL and testbench

Sequences the drain of the PE output buffer into the C result BRAM after a multiplication completes. It also shares the single C BRAM port between that writeback stream and a host readback requester. It sits beside the matrix controller, which hands over at accumulation end. This block owns all C BRAM control until `wb_done`.

---
 rtl/mmul_c_writeback_ctrl.sv | 144 ++++++++++++++
 tb/tb_mmul_c_writeback_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mmul_c_writeback_ctrl.sv
// Drains the PE output buffer into the C BRAM and shares that BRAM port with host reads.
// Define MMUL_C_HOST_RD_EN to enable host read arbitration; otherwise the host port is inert.
module mmul_c_writeback_ctrl #(
    parameter int M        = 3,
    parameter int N        = 3,
    parameter int WB_BURST = 4,
    localparam int ADDR_WIDTH_C = (M * N > 1) ? $clog2(M * N) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wb_start,
    output logic                    pe_output_capture_en,
    output logic                    pe_output_buffer_reset,
    output logic [ADDR_WIDTH_C-1:0] pe_write_idx,
    output logic                    en_c_bram,
    output logic                    we_c_bram,
    output logic [ADDR_WIDTH_C-1:0] addr_c_bram,
    input  logic                    host_rd_req,
    input  logic [ADDR_WIDTH_C-1:0] host_rd_addr,
    output logic                    host_rd_gnt,
    output logic                    host_rd_valid,
    output logic                    wb_busy,
    output logic                    wb_done
);

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        WRITE,
        YIELD,
        DONE
    } state_t;

    localparam logic [ADDR_WIDTH_C-1:0] LAST_IDX = ADDR_WIDTH_C'(M * N - 1);

    state_t                  state;
    logic [ADDR_WIDTH_C-1:0] idx;
    logic                    capture_q;
    logic                    write_q;
    logic                    done_q;
    logic                    busy_q;

`ifdef MMUL_C_HOST_RD_EN
    localparam int BURST_W = (WB_BURST > 1) ? $clog2(WB_BURST) : 1;
    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(WB_BURST - 1);

    logic [BURST_W-1:0] burst_cnt;
    logic               host_slot;

    // The host owns the port in every state except an active write cycle.
    assign host_slot   = (state == IDLE) || (state == CAPTURE) ||
                         (state == YIELD) || (state == DONE);
    assign host_rd_gnt = host_rd_req && host_slot;

    always_ff @(posedge clk) begin
        if (rst) begin
            burst_cnt     <= '0;
            host_rd_valid <= 1'b0;
        end else begin
            host_rd_valid <= host_rd_gnt;
            if (state == WRITE) begin
                burst_cnt <= (burst_cnt == BURST_MAX) ? burst_cnt : burst_cnt + BURST_W'(1);
            end else if (state == IDLE || state == YIELD) begin
                burst_cnt <= '0;
            end
        end
    end
`else
    logic unused_host;

    assign unused_host   = ^{host_rd_req, host_rd_addr};
    assign host_rd_gnt   = 1'b0;
    assign host_rd_valid = 1'b0;
`endif

    // Outputs are registered alongside the state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            capture_q <= 1'b0;
            write_q   <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            capture_q <= 1'b0;
            done_q    <= 1'b0;
            case (state)
                IDLE: begin
                    idx <= '0;
                    if (wb_start) begin
                        state     <= CAPTURE;
                        capture_q <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end
                CAPTURE: begin
                    state   <= WRITE;
                    write_q <= 1'b1;
                end
                WRITE: begin
                    if (idx == LAST_IDX) begin
                        state   <= DONE;
                        idx     <= '0;
                        write_q <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        idx <= idx + ADDR_WIDTH_C'(1);
`ifdef MMUL_C_HOST_RD_EN
                        if (burst_cnt == BURST_MAX && host_rd_req) begin
                            state   <= YIELD;
                            write_q <= 1'b0;
                        end
`endif
                    end
                end
                YIELD: begin
                    state   <= WRITE;
                    write_q <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    idx     <= '0;
                    write_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign pe_output_capture_en   = capture_q;
    assign pe_output_buffer_reset = done_q;
    assign wb_done                = done_q;
    assign wb_busy                = busy_q;
    assign pe_write_idx           = idx;
    assign we_c_bram              = write_q;
    assign en_c_bram              = write_q | host_rd_gnt;
    assign addr_c_bram            = host_rd_gnt ? host_rd_addr : idx;

endmodule

// File: tb/tb_mmul_c_writeback_ctrl.sv
// Directed testbench for mmul_c_writeback_ctrl (M=N=3, WB_BURST=4).
// Host-path expectations follow MMUL_C_HOST_RD_EN.
module tb_mmul_c_writeback_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wb_start = 1'b0;
    logic       host_rd_req = 1'b0;
    logic [3:0] host_rd_addr = 4'd0;
    logic       pe_output_capture_en;
    logic       pe_output_buffer_reset;
    logic [3:0] pe_write_idx;
    logic       en_c_bram;
    logic       we_c_bram;
    logic [3:0] addr_c_bram;
    logic       host_rd_gnt;
    logic       host_rd_valid;
    logic       wb_busy;
    logic       wb_done;

    int total = 0;
    int bad   = 0;

    logic [15:0] obs;

    localparam logic [15:0] MASK_ALL  = 16'hFFFF;
    localparam logic [15:0] MASK_NOPI = 16'hC3FF;
    localparam logic [15:0] MASK_NOAD = 16'hC30F;

    mmul_c_writeback_ctrl #(.M(3), .N(3), .WB_BURST(4)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .wb_start              (wb_start),
        .pe_output_capture_en  (pe_output_capture_en),
        .pe_output_buffer_reset(pe_output_buffer_reset),
        .pe_write_idx          (pe_write_idx),
        .en_c_bram             (en_c_bram),
        .we_c_bram             (we_c_bram),
        .addr_c_bram           (addr_c_bram),
        .host_rd_req           (host_rd_req),
        .host_rd_addr          (host_rd_addr),
        .host_rd_gnt           (host_rd_gnt),
        .host_rd_valid         (host_rd_valid),
        .wb_busy               (wb_busy),
        .wb_done               (wb_done)
    );

    always #5 clk = ~clk;

    assign obs = {pe_output_capture_en, pe_output_buffer_reset, pe_write_idx, en_c_bram,
                  we_c_bram, addr_c_bram, host_rd_gnt, host_rd_valid, wb_busy, wb_done};

    function automatic logic [15:0] pack(input logic cap, input logic bufrst, input logic [3:0] pidx,
                                         input logic en, input logic we, input logic [3:0] addr,
                                         input logic gnt, input logic valid, input logic busy,
                                         input logic done);
        return {cap, bufrst, pidx, en, we, addr, gnt, valid, busy, done};
    endfunction

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in cycle 1 (the CAPTURE cycle).
    task automatic start_pulse;
        wb_start = 1'b1;
        next_cycle();
        wb_start = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        for (int c = 0; c < 5; c++) begin
            next_cycle();
            if (c == 1) rst = 1'b0;
            @(negedge clk);
            total++;
            if (obs !== 16'h0000) begin
                bad++;
                $display("[TB] FAIL reset c%0d: got %h want %h", c, obs, 16'h0000);
            end
        end
        next_cycle();
    endtask

    task automatic test_plain_drain;
        logic [15:0] exp;
        logic [15:0] msk;
        host_rd_req = 1'b0;
        start_pulse();
        for (int c = 1; c <= 12; c++) begin
            msk = MASK_ALL;
            if (c == 1) begin
                exp = pack(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
                msk = MASK_NOAD;
            end else if (c <= 10) begin
                exp = pack(0, 0, 4'(c - 2), 1, 1, 4'(c - 2), 0, 0, 1, 0);
            end else if (c == 11) begin
                exp = pack(0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
                msk = MASK_NOAD;
            end else begin
                exp = 16'h0000;
            end
            @(negedge clk);
            total++;
            if ((obs & msk) !== (exp & msk)) begin
                bad++;
                $display("[TB] FAIL plain_drain c%0d: got %h want %h", c, obs & msk, exp & msk);
            end
            next_cycle();
        end
    endtask

    task automatic test_contended;
        logic [15:0] exp;
        logic [15:0] msk;
        host_rd_req  = 1'b1;
        host_rd_addr = 4'd5;
        start_pulse();
`ifdef MMUL_C_HOST_RD_EN
        for (int c = 1; c <= 16; c++) begin
            msk = MASK_ALL;
            case (c)
                1:  begin exp = pack(1, 0, 0, 1, 0, 5, 1, 1, 1, 0); msk = MASK_NOPI; end
                2, 3, 4, 5:
                    exp = pack(0, 0, 4'(c - 2), 1, 1, 4'(c - 2), 0, c == 2, 1, 0);
                6:  begin exp = pack(0, 0, 0, 1, 0, 5, 1, 0, 1, 0); msk = MASK_NOPI; end
                7, 8, 9, 10:
                    exp = pack(0, 0, 4'(c - 3), 1, 1, 4'(c - 3), 0, c == 7, 1, 0);
                11: begin exp = pack(0, 0, 0, 1, 0, 5, 1, 0, 1, 0); msk = MASK_NOPI; end
                12: exp = pack(0, 0, 8, 1, 1, 8, 0, 1, 1, 0);
                13: begin exp = pack(0, 1, 0, 1, 0, 5, 1, 0, 0, 1); msk = MASK_NOPI; end
                14: exp = pack(0, 0, 0, 1, 0, 5, 1, 1, 0, 0);
                15: exp = pack(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
                default: exp = 16'h0000;
            endcase
            @(negedge clk);
            total++;
            if ((obs & msk) !== (exp & msk)) begin
                bad++;
                $display("[TB] FAIL contended c%0d: got %h want %h", c, obs & msk, exp & msk);
            end
            next_cycle();
            if (c == 14) host_rd_req = 1'b0;
        end
`else
        for (int c = 1; c <= 13; c++) begin
            msk = MASK_ALL;
            if (c == 1) begin
                exp = pack(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
                msk = MASK_NOAD;
            end else if (c <= 10) begin
                exp = pack(0, 0, 4'(c - 2), 1, 1, 4'(c - 2), 0, 0, 1, 0);
            end else if (c == 11) begin
                exp = pack(0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
                msk = MASK_NOAD;
            end else begin
                exp = 16'h0000;
            end
            @(negedge clk);
            total++;
            if ((obs & msk) !== (exp & msk)) begin
                bad++;
                $display("[TB] FAIL contended_nohost c%0d: got %h want %h", c, obs & msk, exp & msk);
            end
            next_cycle();
        end
        host_rd_req = 1'b0;
`endif
        host_rd_addr = 4'd0;
    endtask

    task automatic test_idle_host_read;
        logic [15:0] exp [3];
`ifdef MMUL_C_HOST_RD_EN
        exp[0] = pack(0, 0, 0, 1, 0, 7, 1, 0, 0, 0);
        exp[1] = pack(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
`else
        exp[0] = 16'h0000;
        exp[1] = 16'h0000;
`endif
        exp[2] = 16'h0000;
        host_rd_req  = 1'b1;
        host_rd_addr = 4'd7;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++;
            if (obs !== exp[c]) begin
                bad++;
                $display("[TB] FAIL idle_host_read c%0d: got %h want %h", c, obs, exp[c]);
            end
            next_cycle();
            host_rd_req  = 1'b0;
            host_rd_addr = 4'd0;
        end
    endtask

    task automatic test_abort_restart;
        logic [15:0] exp;
        logic [15:0] msk;
        start_pulse();
        for (int c = 1; c <= 10; c++) begin
            msk = MASK_ALL;
            if (c == 1) begin
                exp = pack(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
                msk = MASK_NOAD;
            end else if (c <= 6) begin
                exp = pack(0, 0, 4'(c - 2), 1, 1, 4'(c - 2), 0, 0, 1, 0);
            end else begin
                exp = 16'h0000;
            end
            @(negedge clk);
            total++;
            if ((obs & msk) !== (exp & msk)) begin
                bad++;
                $display("[TB] FAIL abort c%0d: got %h want %h", c, obs & msk, exp & msk);
            end
            if (c == 3) wb_start = 1'b1;
            if (c == 6) rst = 1'b1;
            next_cycle();
            wb_start = 1'b0;
            rst      = 1'b0;
        end
        start_pulse();
        for (int c = 1; c <= 3; c++) begin
            msk = MASK_ALL;
            if (c == 1) begin
                exp = pack(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
                msk = MASK_NOAD;
            end else begin
                exp = pack(0, 0, 4'(c - 2), 1, 1, 4'(c - 2), 0, 0, 1, 0);
            end
            @(negedge clk);
            total++;
            if ((obs & msk) !== (exp & msk)) begin
                bad++;
                $display("[TB] FAIL restart c%0d: got %h want %h", c, obs & msk, exp & msk);
            end
            next_cycle();
        end
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_plain_drain();
        test_contended();
        test_idle_host_read();
        test_abort_restart();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
